// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The age comparison helper lives here so both sources agree on what "older" means.
package regfile_wb_pkg;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int SEQ_W    = 4;
    localparam int WB_DEPTH = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } wb_entry_t;

    // a is older than b when b is ahead of a by less than half the stamp range.
    function automatic logic seq_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = b - a;
        return (diff != '0) && (diff[SEQ_W-1] == 1'b0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small per-source writeback FIFO (module wb_src_fifo). Exposes the head entry plus
// every slot's valid/address so the top level can answer hazard queries.
module wb_src_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_push,
    input  wb_entry_t                         i_push_entry,
    input  logic                              i_pop,
    output logic                              o_full,
    output logic                              o_head_valid,
    output wb_entry_t                         o_head,
    output logic [DEPTH-1:0]                  o_ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]      o_ent_addr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;

    logic               w_do_push;
    logic               w_do_pop;

    // Push is refused when full even if a pop happens on the same edge.
    assign w_do_push    = i_push && !o_full;
    assign w_do_pop     = i_pop && o_head_valid;
    assign o_full       = &r_valid;
    assign o_head_valid = r_valid[r_rd_ptr];
    assign o_head       = r_mem[r_rd_ptr];

    always_comb begin
        o_ent_valid = r_valid;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_addr[i] = r_mem[i].addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks, one write per cycle,
// and flags reads whose register still has a write queued or in flight.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2
);

    logic [SEQ_W-1:0]  r_seq;
    src_e              r_last_grant;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic                         w_alu_push, w_mem_push;
    logic                         w_alu_pop, w_mem_pop;
    logic                         w_alu_full, w_mem_full;
    logic                         w_alu_head_valid, w_mem_head_valid;
    wb_entry_t                    w_alu_head, w_mem_head;
    wb_entry_t                    w_alu_entry, w_mem_entry;
    logic [DEPTH-1:0]             w_alu_ent_valid, w_mem_ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] w_alu_ent_addr, w_mem_ent_addr;

    logic      w_grant;
    logic      w_rr;
    src_e      w_win;
    wb_entry_t w_win_entry;
    logic      w_match1, w_match2;

    assign alu_ready  = !w_alu_full;
    assign mem_ready  = !w_mem_full;
    assign w_alu_push = alu_valid && !w_alu_full;
    assign w_mem_push = mem_valid && !w_mem_full;

    assign w_alu_entry = '{addr: alu_addr, data: alu_data, seq: r_seq};
    assign w_mem_entry = '{addr: mem_addr, data: mem_data, seq: r_seq};

    wb_src_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_push       (w_alu_push),
        .i_push_entry (w_alu_entry),
        .i_pop        (w_alu_pop),
        .o_full       (w_alu_full),
        .o_head_valid (w_alu_head_valid),
        .o_head       (w_alu_head),
        .o_ent_valid  (w_alu_ent_valid),
        .o_ent_addr   (w_alu_ent_addr)
    );

    wb_src_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_push       (w_mem_push),
        .i_push_entry (w_mem_entry),
        .i_pop        (w_mem_pop),
        .o_full       (w_mem_full),
        .o_head_valid (w_mem_head_valid),
        .o_head       (w_mem_head),
        .o_ent_valid  (w_mem_ent_valid),
        .o_ent_addr   (w_mem_ent_addr)
    );

    // Same-register heads go oldest-first; equal stamps mean MEM was accepted alongside, so MEM wins.
    always_comb begin
        w_grant = 1'b0;
        w_rr    = 1'b0;
        w_win   = SRC_ALU;
        if (w_alu_head_valid && w_mem_head_valid) begin
            w_grant = 1'b1;
            if ((w_alu_head.addr == w_mem_head.addr) && (w_alu_head.addr != '0)) begin
                w_win = seq_older(w_alu_head.seq, w_mem_head.seq) ? SRC_ALU : SRC_MEM;
            end else begin
                w_rr  = 1'b1;
                w_win = (r_last_grant == SRC_ALU) ? SRC_MEM : SRC_ALU;
            end
        end else if (w_alu_head_valid) begin
            w_grant = 1'b1;
            w_win   = SRC_ALU;
        end else if (w_mem_head_valid) begin
            w_grant = 1'b1;
            w_win   = SRC_MEM;
        end
    end

    assign w_win_entry = (w_win == SRC_MEM) ? w_mem_head : w_alu_head;
    assign w_alu_pop   = w_grant && (w_win == SRC_ALU);
    assign w_mem_pop   = w_grant && (w_win == SRC_MEM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq        <= '0;
            r_last_grant <= SRC_MEM;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            if (w_alu_push || w_mem_push) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            // Only a round-robin decision moves the fairness pointer.
            if (w_rr) begin
                r_last_grant <= w_win;
            end
            r_wr_en <= w_grant && (w_win_entry.addr != '0);
            if (w_grant) begin
                r_wr_addr <= w_win_entry.addr;
                r_wr_data <= w_win_entry.data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    always_comb begin
        w_match1 = r_wr_en && (r_wr_addr == rd_addr1);
        w_match2 = r_wr_en && (r_wr_addr == rd_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alu_ent_valid[i] && (w_alu_ent_addr[i] == rd_addr1)) w_match1 = 1'b1;
            if (w_mem_ent_valid[i] && (w_mem_ent_addr[i] == rd_addr1)) w_match1 = 1'b1;
            if (w_alu_ent_valid[i] && (w_alu_ent_addr[i] == rd_addr2)) w_match2 = 1'b1;
            if (w_mem_ent_valid[i] && (w_mem_ent_addr[i] == rd_addr2)) w_match2 = 1'b1;
        end
    end

    assign hazard1 = (rd_addr1 != '0) && w_match1;
    assign hazard2 = (rd_addr2 != '0) && w_match2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int DEPTH = WB_DEPTH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              alu_valid = 1'b0, mem_valid = 1'b0;
    logic              alu_ready, mem_ready;
    logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0;
    logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1 = '0, rd_addr2 = '0;
    logic              hazard1, hazard2;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues in arrival order; key is a never-wrapping arrival rank
    // (MEM ranks ahead of ALU when both arrive on the same edge).
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                key;
    } m_ent_t;

    m_ent_t            m_alu[$];
    m_ent_t            m_mem[$];
    int                m_acc_edges = 0;
    bit                m_last_mem = 1'b1;
    bit                m_wr_en = 1'b0;
    logic [ADDR_W-1:0] m_wr_addr = '0;
    logic [DATA_W-1:0] m_wr_data = '0;
    bit                model_live = 1'b0;

    always @(posedge clk) begin : ref_model
        bit     a_acc;
        bit     m_acc;
        int     win;
        m_ent_t e;
        if (reset) begin
            m_alu.delete();
            m_mem.delete();
            m_acc_edges = 0;
            m_last_mem  = 1'b1;
            m_wr_en     = 1'b0;
            m_wr_addr   = '0;
            m_wr_data   = '0;
            model_live  = 1'b1;
        end else begin
            a_acc = alu_valid && (m_alu.size() < DEPTH);
            m_acc = mem_valid && (m_mem.size() < DEPTH);
            win = 0;
            if (m_alu.size() > 0 && m_mem.size() > 0) begin
                if (m_alu[0].addr == m_mem[0].addr && m_alu[0].addr != '0) begin
                    win = (m_alu[0].key < m_mem[0].key) ? 1 : 2;
                end else begin
                    win = m_last_mem ? 1 : 2;
                    m_last_mem = (win == 2);
                end
            end else if (m_alu.size() > 0) begin
                win = 1;
            end else if (m_mem.size() > 0) begin
                win = 2;
            end
            m_wr_en = 1'b0;
            if (win != 0) begin
                if (win == 1) e = m_alu.pop_front();
                else          e = m_mem.pop_front();
                m_wr_en   = (e.addr != '0);
                m_wr_addr = e.addr;
                m_wr_data = e.data;
            end
            if (a_acc) m_alu.push_back('{alu_addr, alu_data, 2 * m_acc_edges + 1});
            if (m_acc) m_mem.push_back('{mem_addr, mem_data, 2 * m_acc_edges});
            if (a_acc || m_acc) m_acc_edges++;
        end
    end

    function automatic bit m_hazard(input logic [ADDR_W-1:0] rd);
        if (rd == '0) return 1'b0;
        if (m_wr_en && m_wr_addr == rd) return 1'b1;
        foreach (m_alu[i]) if (m_alu[i].addr == rd) return 1'b1;
        foreach (m_mem[i]) if (m_mem[i].addr == rd) return 1'b1;
        return 1'b0;
    endfunction

    logic [ADDR_W-1:0] obs_addr[$];
    logic [DATA_W-1:0] obs_data[$];

    always @(negedge clk) begin
        if (model_live) begin
            check("wr_en", 64'(wr_en), 64'(m_wr_en));
            if (m_wr_en) begin
                check("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
                check("wr_data", 64'(wr_data), 64'(m_wr_data));
            end
            check("alu_ready", 64'(alu_ready), 64'(m_alu.size() < DEPTH));
            check("mem_ready", 64'(mem_ready), 64'(m_mem.size() < DEPTH));
            check("hazard1", 64'(hazard1), 64'(m_hazard(rd_addr1)));
            check("hazard2", 64'(hazard2), 64'(m_hazard(rd_addr2)));
            if (wr_en) begin
                obs_addr.push_back(wr_addr);
                obs_data.push_back(wr_data);
            end
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t alu_pend[$];
    req_t mem_pend[$];
    bit   saw_alu_stall = 1'b0;
    bit   saw_mem_stall = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic add_req(input bit is_mem, input int addr, input logic [DATA_W-1:0] data);
        req_t r;
        r.addr = ADDR_W'(addr);
        r.data = data;
        if (is_mem) mem_pend.push_back(r);
        else        alu_pend.push_back(r);
    endtask

    // Presents pending requests; a stalled request keeps valid and data until accepted.
    task automatic pump(input int max_cyc, input bit rnd);
        int cyc;
        bit a_acc, m_acc, a_hold, m_hold;
        cyc = 0;
        a_hold = 1'b0;
        m_hold = 1'b0;
        while ((alu_pend.size() > 0 || mem_pend.size() > 0) && cyc < max_cyc) begin
            alu_valid = (alu_pend.size() > 0) && (a_hold || !rnd || ($urandom_range(0, 3) != 0));
            mem_valid = (mem_pend.size() > 0) && (m_hold || !rnd || ($urandom_range(0, 3) != 0));
            if (alu_valid) begin
                alu_addr = alu_pend[0].addr;
                alu_data = alu_pend[0].data;
            end
            if (mem_valid) begin
                mem_addr = mem_pend[0].addr;
                mem_data = mem_pend[0].data;
            end
            if (rnd) begin
                rd_addr1 = ADDR_W'($urandom_range(0, 7));
                rd_addr2 = ADDR_W'($urandom_range(0, 7));
            end
            a_acc = alu_valid && alu_ready;
            m_acc = mem_valid && mem_ready;
            if (alu_valid && !alu_ready) saw_alu_stall = 1'b1;
            if (mem_valid && !mem_ready) saw_mem_stall = 1'b1;
            step();
            cyc++;
            if (a_acc) void'(alu_pend.pop_front());
            if (m_acc) void'(mem_pend.pop_front());
            a_hold = alu_valid && !a_acc;
            m_hold = mem_valid && !m_acc;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check("pump_drained", 64'(alu_pend.size() + mem_pend.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] r7_vals[$];

        // 1: reset state and single ALU write latency
        repeat (3) step();
        reset = 1'b0;
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd1);
        check("rst_mem_ready", 64'(mem_ready), 64'd1);
        alu_valid = 1'b1;
        alu_addr  = 6'd5;
        alu_data  = 32'h11;
        step();
        alu_valid = 1'b0;
        check("t1_cycle1_wr_en", 64'(wr_en), 64'd0);
        step();
        check("t1_cycle2_wr_en", 64'(wr_en), 64'd1);
        check("t1_cycle2_wr_addr", 64'(wr_addr), 64'd5);
        check("t1_cycle2_wr_data", 64'(wr_data), 64'h11);
        step();

        // 2: both sources saturating with distinct registers
        do_reset();
        obs_addr.delete();
        obs_data.delete();
        for (int i = 0; i < 6; i++) begin
            add_req(1'b0, 1 + i, 32'h100 + 32'(i));
            add_req(1'b1, 9 + i, 32'h200 + 32'(i));
        end
        pump(60, 1'b0);
        repeat (4) step();
        check("t2_write_count", 64'(obs_addr.size()), 64'd12);
        check("t2_first_addr", 64'(obs_addr[0]), 64'd1);
        check("t2_second_addr", 64'(obs_addr[1]), 64'd9);
        check("t2_third_addr", 64'(obs_addr[2]), 64'd2);

        // 3: same register from both sources, older entry first
        do_reset();
        obs_addr.delete();
        obs_data.delete();
        mem_valid = 1'b1;
        mem_addr  = 6'd7;
        mem_data  = 32'hA;
        alu_valid = 1'b1;
        alu_addr  = 6'd3;
        alu_data  = 32'h33;
        step();
        mem_valid = 1'b0;
        alu_addr  = 6'd7;
        alu_data  = 32'hB;
        step();
        alu_valid = 1'b0;
        repeat (5) step();
        foreach (obs_addr[i]) if (obs_addr[i] == 6'd7) r7_vals.push_back(obs_data[i]);
        check("t3_r7_count", 64'(r7_vals.size()), 64'd2);
        check("t3_r7_first", 64'(r7_vals[0]), 64'hA);
        check("t3_r7_final", 64'(r7_vals[r7_vals.size() - 1]), 64'hB);

        // 4: writes to r0 are popped silently and never hazard
        do_reset();
        obs_addr.delete();
        obs_data.delete();
        rd_addr1  = '0;
        alu_valid = 1'b1;
        alu_addr  = 6'd0;
        alu_data  = 32'hFF;
        step();
        alu_valid = 1'b0;
        check("t4_hazard_r0", 64'(hazard1), 64'd0);
        repeat (4) step();
        check("t4_no_write", 64'(obs_addr.size()), 64'd0);
        check("t4_alu_ready", 64'(alu_ready), 64'd1);

        // 5: backpressure on both sources, then random traffic across stamp wrap
        do_reset();
        saw_alu_stall = 1'b0;
        saw_mem_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            add_req(1'b0, 16 + i, 32'h300 + 32'(i));
            add_req(1'b1, 24 + i, 32'h400 + 32'(i));
        end
        pump(60, 1'b0);
        check("t5_alu_stalled", 64'(saw_alu_stall), 64'd1);
        check("t5_mem_stalled", 64'(saw_mem_stall), 64'd1);
        for (int i = 0; i < 40; i++) begin
            add_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
        end
        pump(600, 1'b1);
        repeat (6) step();

        // 6: reset discards queued entries
        do_reset();
        rd_addr1  = 6'd12;
        rd_addr2  = 6'd13;
        alu_valid = 1'b1;
        alu_addr  = 6'd12;
        alu_data  = 32'hC0;
        mem_valid = 1'b1;
        mem_addr  = 6'd13;
        mem_data  = 32'hD0;
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check("t6_hazard1_queued", 64'(hazard1), 64'd1);
        check("t6_hazard2_queued", 64'(hazard2), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_hazard1_cleared", 64'(hazard1), 64'd0);
        check("t6_hazard2_cleared", 64'(hazard2), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6_wr_en_quiet", 64'(wr_en), 64'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
